// File: rtl/ace_line_xfer_pkg.sv
// ============================================================================
// ace_pkg : ACE encodings and transfer-engine state type  |  rev 1.0
// ============================================================================
`default_nettype none

package ace_pkg;
  localparam logic [3:0] AR_SNOOP_READ_SHARED = 4'b0001;
  localparam logic [3:0] AR_SNOOP_READ_UNIQUE = 4'b0111;
  localparam logic [2:0] AW_SNOOP_WRITEBACK   = 3'b011;
  localparam logic [1:0] BURST_INCR           = 2'b01;
  localparam logic [1:0] RESP_OKAY            = 2'b00;
  localparam logic [1:0] RESP_EXOKAY          = 2'b01;
  localparam logic [1:0] RESP_SLVERR          = 2'b10;
  localparam logic [1:0] RESP_DECERR          = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_DONE = 3'd6
  } xfer_state_e;
endpackage

`default_nettype wire

// File: rtl/ace_line_xfer_if.sv
// ============================================================================
// ace_line_xfer_if : controller request/response and ACE AR/R/AW/W/B bundle  |  rev 1.0
// ============================================================================
`default_nettype none

interface ace_line_xfer_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int BEATS   = 4
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_evict;
  logic                       req_unique;
  logic [WIDTH_A-1:0]         req_fill_addr;
  logic [WIDTH_A-1:0]         req_evict_addr;
  logic [WIDTH_D*BEATS-1:0]   req_evict_line;
  logic [WIDTH_D*BEATS-1:0]   fill_line;
  logic                       fill_pd;
  logic                       fill_is;
  logic                       done;
  logic                       err;

  logic                       AW_VALID;
  logic                       AW_READY;
  logic [WIDTH_A-1:0]         AW_ADDR;
  logic [7:0]                 AW_LEN;
  logic [2:0]                 AW_SIZE;
  logic [1:0]                 AW_BURST;
  logic [2:0]                 AW_SNOOP;
  logic                       W_VALID;
  logic                       W_READY;
  logic [WIDTH_D-1:0]         W_DATA;
  logic                       W_LAST;
  logic                       B_VALID;
  logic                       B_READY;
  logic [1:0]                 BRESP;
  logic                       AR_VALID;
  logic                       AR_READY;
  logic [WIDTH_A-1:0]         AR_ADDR;
  logic [7:0]                 AR_LEN;
  logic [2:0]                 AR_SIZE;
  logic [1:0]                 AR_BURST;
  logic [3:0]                 AR_SNOOP;
  logic                       R_VALID;
  logic                       R_READY;
  logic [WIDTH_D-1:0]         RDATA;
  logic [3:0]                 RRESP;
  logic                       R_LAST;

  modport master (
    input  req_valid, req_evict, req_unique, req_fill_addr, req_evict_addr, req_evict_line,
    output req_ready, fill_line, fill_pd, fill_is, done, err,
    output AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_SNOOP,
    input  AW_READY,
    output W_VALID, W_DATA, W_LAST,
    input  W_READY,
    input  B_VALID, BRESP,
    output B_READY,
    output AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_SNOOP,
    input  AR_READY,
    input  R_VALID, RDATA, RRESP, R_LAST,
    output R_READY
  );

  modport slave (
    output req_valid, req_evict, req_unique, req_fill_addr, req_evict_addr, req_evict_line,
    input  req_ready, fill_line, fill_pd, fill_is, done, err,
    input  AW_VALID, AW_ADDR, AW_LEN, AW_SIZE, AW_BURST, AW_SNOOP,
    output AW_READY,
    input  W_VALID, W_DATA, W_LAST,
    output W_READY,
    output B_VALID, BRESP,
    input  B_READY,
    input  AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_SNOOP,
    output AR_READY,
    output R_VALID, RDATA, RRESP, R_LAST,
    input  R_READY
  );
endinterface

`default_nettype wire

// File: rtl/ace_line_xfer_beat_counter.sv
// ============================================================================
// beat_counter : burst beat index with clear, increment and last-beat flag  |  rev 1.0
// ============================================================================
`default_nettype none

module beat_counter #(
  parameter int WIDTH = 2,
  parameter int LAST  = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_inc,
  output logic [WIDTH-1:0]      o_cnt,
  output logic                  o_last
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == WIDTH'(LAST));
endmodule

`default_nettype wire

// File: rtl/ace_line_xfer.sv
// ============================================================================
// ace_line_xfer : victim WriteBack burst then ReadShared/ReadUnique line fill  |  rev 1.0
// ============================================================================
`default_nettype none

module ace_line_xfer
  import ace_pkg::*;
#(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int BEATS   = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ace_line_xfer_if.master bus
);
  localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS = $clog2(BEATS * WIDTH_D / 8);
  localparam logic [WIDTH_A-1:0] C_ADDR_MASK = ~((WIDTH_A'(1) << OFFS) - WIDTH_A'(1));

  xfer_state_e                    r_state;
  xfer_state_e                    w_next;
  logic                           r_unique;
  logic [WIDTH_A-1:0]             r_fill_addr;
  logic [WIDTH_A-1:0]             r_evict_addr;
  logic [BEATS-1:0][WIDTH_D-1:0]  r_evict_line;
  logic [BEATS-1:0][WIDTH_D-1:0]  r_fill_line;
  logic                           r_err;
  logic                           r_pd;
  logic                           r_is;
  logic [CW-1:0]                  w_cnt;
  logic                           w_last;
  logic                           w_clr;
  logic                           w_inc;
  logic                           w_req_ready;
  logic                           w_aw_valid;
  logic                           w_w_valid;
  logic                           w_b_ready;
  logic                           w_ar_valid;
  logic                           w_r_ready;
  logic                           w_done;
  logic                           w_r_bad;
  logic                           w_r_end;

  beat_counter #(.WIDTH(CW), .LAST(BEATS - 1)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  // A fill ends on R_LAST or the final beat slot; any disagreement between them is an error.
  assign w_r_end = bus.R_LAST || w_last;
  assign w_r_bad = (bus.RRESP[1:0] != RESP_OKAY) || (bus.R_LAST != w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_req_ready = 1'b0;
    w_aw_valid  = 1'b0;
    w_w_valid   = 1'b0;
    w_b_ready   = 1'b0;
    w_ar_valid  = 1'b0;
    w_r_ready   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_next = bus.req_evict ? ST_AW : ST_AR;
      end
      ST_AW: begin
        w_aw_valid = 1'b1;
        w_clr      = 1'b1;
        if (bus.AW_READY) w_next = ST_W;
      end
      ST_W: begin
        w_w_valid = 1'b1;
        if (bus.W_READY) begin
          w_inc = 1'b1;
          if (w_last) w_next = ST_B;
        end
      end
      ST_B: begin
        w_b_ready = 1'b1;
        if (bus.B_VALID) w_next = ST_AR;
      end
      ST_AR: begin
        w_ar_valid = 1'b1;
        w_clr      = 1'b1;
        if (bus.AR_READY) w_next = ST_R;
      end
      ST_R: begin
        w_r_ready = 1'b1;
        if (bus.R_VALID) begin
          w_inc = 1'b1;
          if (w_r_end) w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unique     <= 1'b0;
      r_fill_addr  <= '0;
      r_evict_addr <= '0;
      r_evict_line <= '0;
      r_fill_line  <= '0;
      r_err        <= 1'b0;
      r_pd         <= 1'b0;
      r_is         <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid) begin
        r_unique     <= bus.req_unique;
        r_fill_addr  <= bus.req_fill_addr;
        r_evict_addr <= bus.req_evict_addr;
        r_evict_line <= bus.req_evict_line;
      end
      if (r_state == ST_B && bus.B_VALID && bus.BRESP != RESP_OKAY) r_err <= 1'b1;
      if (r_state == ST_R && bus.R_VALID) begin
        r_fill_line[w_cnt] <= bus.RDATA;
        if (w_r_bad) r_err <= 1'b1;
        if (w_r_end) begin
          r_pd <= bus.RRESP[2];
          r_is <= bus.RRESP[3];
        end
      end
      if (r_state == ST_DONE) r_err <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.fill_line = r_fill_line;
  assign bus.fill_pd   = r_pd;
  assign bus.fill_is   = r_is;
  assign bus.done      = w_done;
  assign bus.err       = w_done & r_err;

  assign bus.AW_VALID  = w_aw_valid;
  assign bus.AW_ADDR   = r_evict_addr & C_ADDR_MASK;
  assign bus.AW_LEN    = 8'(BEATS - 1);
  assign bus.AW_SIZE   = 3'($clog2(WIDTH_D / 8));
  assign bus.AW_BURST  = BURST_INCR;
  assign bus.AW_SNOOP  = AW_SNOOP_WRITEBACK;
  assign bus.W_VALID   = w_w_valid;
  assign bus.W_DATA    = r_evict_line[w_cnt];
  assign bus.W_LAST    = w_last;
  assign bus.B_READY   = w_b_ready;
  assign bus.AR_VALID  = w_ar_valid;
  assign bus.AR_ADDR   = r_fill_addr & C_ADDR_MASK;
  assign bus.AR_LEN    = 8'(BEATS - 1);
  assign bus.AR_SIZE   = 3'($clog2(WIDTH_D / 8));
  assign bus.AR_BURST  = BURST_INCR;
  assign bus.AR_SNOOP  = r_unique ? AR_SNOOP_READ_UNIQUE : AR_SNOOP_READ_SHARED;
  assign bus.R_READY   = w_r_ready;
endmodule

`default_nettype wire

// File: tb/tb_ace_line_xfer.sv
// ============================================================================
// tb_ace_line_xfer : directed checks of the line transfer engine  |  rev 1.0
// ============================================================================
`default_nettype none

module tb_ace_line_xfer;
  localparam int WA  = 32;
  localparam int WD  = 32;
  localparam int NB  = 4;
  localparam int LIM = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc = 0;
  int          td = 0;
  logic [31:0] rd [4];
  logic [127:0] line1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ace_line_xfer_if #(.WIDTH_A(WA), .WIDTH_D(WD), .BEATS(NB)) bus ();

  ace_line_xfer #(.WIDTH_A(WA), .WIDTH_D(WD), .BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_send(input logic ev, input logic un, input logic [31:0] fa,
                          input logic [31:0] ea, input logic [127:0] ln);
    bus.req_valid = 1'b1; bus.req_evict = ev; bus.req_unique = un;
    bus.req_fill_addr = fa; bus.req_evict_addr = ea; bus.req_evict_line = ln;
    for (int n = 0; n < LIM && !bus.req_ready; n++) @(negedge clk);
    chk("req_ready", bus.req_ready, 1'b1);
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic aw_accept(input logic [31:0] addr, input int stall);
    for (int n = 0; n < LIM && !bus.AW_VALID; n++) @(negedge clk);
    chk("aw_valid", bus.AW_VALID, 1'b1);
    chk("aw_addr", bus.AW_ADDR, addr);
    chk("aw_fields", {bus.AW_LEN, bus.AW_SIZE, bus.AW_BURST, bus.AW_SNOOP}, {8'd3, 3'd2, 2'b01, 3'b011});
    chk("w_before_aw", bus.W_VALID, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("aw_hold", {bus.AW_VALID, bus.AW_ADDR, bus.W_VALID}, {1'b1, addr, 1'b0});
    end
    bus.AW_READY = 1'b1;
    @(negedge clk);
    bus.AW_READY = 1'b0;
  endtask

  task automatic w_accept(input logic [31:0] data, input logic last, input int stall);
    for (int n = 0; n < LIM && !bus.W_VALID; n++) @(negedge clk);
    chk("w_beat", {bus.W_VALID, bus.W_DATA, bus.W_LAST}, {1'b1, data, last});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("w_hold", {bus.W_VALID, bus.W_DATA, bus.W_LAST}, {1'b1, data, last});
    end
    bus.W_READY = 1'b1;
    @(negedge clk);
    bus.W_READY = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp);
    bus.B_VALID = 1'b1; bus.BRESP = resp;
    for (int n = 0; n < LIM && !bus.B_READY; n++) begin
      chk("ar_before_b", bus.AR_VALID, 1'b0);
      @(negedge clk);
    end
    chk("b_ready", {bus.B_READY, bus.AR_VALID}, {1'b1, 1'b0});
    @(negedge clk);
    bus.B_VALID = 1'b0; bus.BRESP = 2'b00;
  endtask

  task automatic ar_accept(input logic [31:0] addr, input logic [3:0] snoop, input int stall);
    for (int n = 0; n < LIM && !bus.AR_VALID; n++) @(negedge clk);
    chk("ar_valid", bus.AR_VALID, 1'b1);
    chk("ar_addr", bus.AR_ADDR, addr);
    chk("ar_fields", {bus.AR_LEN, bus.AR_SIZE, bus.AR_BURST, bus.AR_SNOOP}, {8'd3, 3'd2, 2'b01, snoop});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("ar_hold", {bus.AR_VALID, bus.AR_ADDR, bus.AR_SNOOP}, {1'b1, addr, snoop});
    end
    bus.AR_READY = 1'b1;
    @(negedge clk);
    bus.AR_READY = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [3:0] resp, input logic last, input int stall);
    for (int s = 0; s < stall; s++) @(negedge clk);
    bus.R_VALID = 1'b1; bus.RDATA = data; bus.RRESP = resp; bus.R_LAST = last;
    for (int n = 0; n < LIM && !bus.R_READY; n++) @(negedge clk);
    chk("r_ready", bus.R_READY, 1'b1);
    @(negedge clk);
    bus.R_VALID = 1'b0; bus.R_LAST = 1'b0; bus.RRESP = 4'b0000;
  endtask

  task automatic wait_done();
    for (int n = 0; n < LIM && !bus.done; n++) @(negedge clk);
    chk("done", bus.done, 1'b1);
  endtask

  initial begin
    rd[0] = 32'hAAAAAAAA; rd[1] = 32'hBBBBBBBB; rd[2] = 32'hCCCCCCCC; rd[3] = 32'hDDDDDDDD;
    line1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    bus.req_valid = 1'b0; bus.req_evict = 1'b0; bus.req_unique = 1'b0;
    bus.req_fill_addr = '0; bus.req_evict_addr = '0; bus.req_evict_line = '0;
    bus.AW_READY = 1'b0; bus.W_READY = 1'b0; bus.B_VALID = 1'b0; bus.BRESP = 2'b00;
    bus.AR_READY = 1'b0; bus.R_VALID = 1'b0; bus.RDATA = '0; bus.RRESP = '0; bus.R_LAST = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_outs", {bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.AR_VALID, bus.R_READY,
                     bus.done, bus.err, bus.fill_pd, bus.fill_is}, 9'd0);
    chk("rst_line", bus.fill_line, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain shared fill with zero-wait slave.
    req_send(1'b0, 1'b0, 32'h00000018, 32'h0, 128'h0);
    ar_accept(32'h00000010, 4'b0001, 0);
    for (int k = 0; k < 4; k++) r_beat(rd[k], 4'b1000, k == 3, 0);
    wait_done();
    chk("t1_latency", cyc - acc, 6);
    chk("t1_line", bus.fill_line, line1);
    chk("t1_pd_is_err", {bus.fill_pd, bus.fill_is, bus.err}, 3'b010);
    @(negedge clk);
    chk("t1_pulse", {bus.done, bus.req_ready}, 2'b01);

    // Writeback then unique fill.
    req_send(1'b1, 1'b1, 32'h00000010, 32'h01000010, {4{32'hFEEDBEEF}});
    aw_accept(32'h01000010, 0);
    for (int k = 0; k < 4; k++) w_accept(32'hFEEDBEEF, k == 3, 0);
    b_resp(2'b00);
    ar_accept(32'h00000010, 4'b0111, 0);
    for (int k = 0; k < 4; k++) r_beat(32'h10000001 + k, (k == 3) ? 4'b0100 : 4'b0000, k == 3, 0);
    wait_done();
    chk("t2_line", bus.fill_line, 128'h10000004_10000003_10000002_10000001);
    chk("t2_pd_is_err", {bus.fill_pd, bus.fill_is, bus.err}, 3'b100);

    // SLVERR on writeback: fill still runs, error reported.
    req_send(1'b1, 1'b0, 32'h00000044, 32'h0200003C, 128'h04040404_03030303_02020202_01010101);
    aw_accept(32'h02000030, 0);
    for (int k = 0; k < 4; k++) w_accept(32'h01010101 * (k + 1), k == 3, 0);
    b_resp(2'b10);
    ar_accept(32'h00000040, 4'b0001, 0);
    for (int k = 0; k < 4; k++) r_beat(32'h30000000 + k, 4'b0000, k == 3, 0);
    wait_done();
    chk("t3_line", bus.fill_line, 128'h30000003_30000002_30000001_30000000);
    chk("t3_err", bus.err, 1'b1);

    // Early R_LAST on beat 1: partial line, error, no further beats.
    req_send(1'b0, 1'b0, 32'h00000020, 32'h0, 128'h0);
    ar_accept(32'h00000020, 4'b0001, 0);
    r_beat(32'h40000000, 4'b0000, 1'b0, 0);
    r_beat(32'h40000001, 4'b1100, 1'b1, 0);
    chk("t4_done", {bus.done, bus.err, bus.R_READY, bus.req_ready}, 4'b1100);
    chk("t4_line", bus.fill_line, 128'h30000003_30000002_40000001_40000000);
    chk("t4_pd_is", {bus.fill_pd, bus.fill_is}, 2'b11);
    td = cyc;

    // Request raised during DONE, then stalled writeback + fill.
    req_send(1'b1, 1'b0, 32'h00000018, 32'h00800000, 128'h0A000004_0A000003_0A000002_0A000001);
    chk("t5_accept_after_done", acc - td, 1);
    aw_accept(32'h00800000, $urandom_range(0, 5));
    for (int k = 0; k < 4; k++) w_accept(32'h0A000001 + k, k == 3, $urandom_range(0, 5));
    b_resp(2'b00);
    ar_accept(32'h00000010, 4'b0001, $urandom_range(0, 5));
    for (int k = 0; k < 4; k++) r_beat(rd[k], 4'b1000, k == 3, $urandom_range(0, 5));
    wait_done();
    chk("t5_line", bus.fill_line, line1);
    chk("t5_pd_is_err", {bus.fill_pd, bus.fill_is, bus.err}, 3'b010);

    // Asynchronous reset in the middle of the W burst.
    @(negedge clk);
    req_send(1'b1, 1'b0, 32'h00000018, 32'h00400000, 128'h5);
    aw_accept(32'h00400000, 0);
    w_accept(32'h00000005, 1'b0, 0);
    w_accept(32'h00000000, 1'b0, 0);
    chk("t6_mid_w", bus.W_VALID, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_outs", {bus.req_ready, bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.AR_VALID,
                        bus.R_READY, bus.done, bus.err, bus.fill_pd, bus.fill_is}, 10'b10_0000_0000);
    chk("t6_rst_line", bus.fill_line, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_send(1'b0, 1'b0, 32'h0000001C, 32'h0, 128'h0);
    ar_accept(32'h00000010, 4'b0001, 0);
    for (int k = 0; k < 4; k++) r_beat(rd[k], 4'b1000, k == 3, 0);
    wait_done();
    chk("t6_line", bus.fill_line, line1);
    chk("t6_err", bus.err, 1'b0);

    // Missing R_LAST on the final beat slot.
    @(negedge clk);
    req_send(1'b0, 1'b1, 32'h0000010C, 32'h0, 128'h0);
    ar_accept(32'h00000100, 4'b0111, 0);
    for (int k = 0; k < 4; k++) r_beat(32'h70000000 + k, 4'b0000, 1'b0, 0);
    chk("t7_done", {bus.done, bus.err, bus.R_READY}, 3'b110);
    chk("t7_line", bus.fill_line, 128'h70000003_70000002_70000001_70000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
